// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux select arbiter.
package mux_arb_pkg;

  localparam int unsigned GNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_X = 2'd1,
    GRANT_Y = 2'd2,
    DEAD    = 2'd3
  } arb_state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
  localparam logic [GNT_W-1:0] GNT_X    = 2'b01;
  localparam logic [GNT_W-1:0] GNT_Y    = 2'b10;

  // One-hot grant vector implied by an arbiter state.
  function automatic logic [GNT_W-1:0] gnt_of_state(input arb_state_e s);
    case (s)
      GRANT_X: return GNT_X;
      GRANT_Y: return GNT_Y;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mux_select_arbiter_tenure_counter.sv
// Saturating tenure counter: clear restarts the tenure (at 1 if also enabled),
// enable counts granted cycles; expired is high once the count reaches HOLD_CYCLES.
module tenure_counter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = enable ? CNT_W'(1) : '0;
    end else if (enable && (cnt_q < HOLD)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Registered flag tracks the count it will be compared against next cycle.
    expired_d = (cnt_d >= HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/mux_select_arbiter.sv
// Two-requester round-robin arbiter driving the 2:1 data mux select with minimum tenure.
// Optional break-before-make DEAD cycle enabled by MUX_SELECT_ARBITER_DEADTIME_EN.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [GNT_W-1:0] req,
  output logic [GNT_W-1:0] gnt,
  output logic             sel,
  output logic             out_en,
  output logic             busy
);

`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
  localparam arb_state_e SWITCH_TO_X = DEAD;
  localparam arb_state_e SWITCH_TO_Y = DEAD;
`else
  localparam arb_state_e SWITCH_TO_X = GRANT_X;
  localparam arb_state_e SWITCH_TO_Y = GRANT_Y;
`endif

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic             sel_q, sel_d;
  logic             out_en_q, out_en_d;
  logic             busy_q, busy_d;
  logic             last_owner_q, last_owner_d;
  logic             cnt_clear, cnt_enable, expired;

  tenure_counter #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_tenure (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  // Next-state: release on drop, preempt only once tenure has expired.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (req)
          2'b01:   state_d = GRANT_X;
          2'b10:   state_d = GRANT_Y;
          2'b11:   state_d = (last_owner_q == SEL_Y) ? GRANT_X : GRANT_Y;
          default: state_d = IDLE;
        endcase
      end
      GRANT_X: begin
        if (!req[0] || (req[1] && expired)) begin
          state_d = req[1] ? SWITCH_TO_Y : IDLE;
        end
      end
      GRANT_Y: begin
        if (!req[1] || (req[0] && expired)) begin
          state_d = req[0] ? SWITCH_TO_X : IDLE;
        end
      end
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
      DEAD:    state_d = (sel_q == SEL_Y) ? GRANT_Y : GRANT_X;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output/owner decode from the next state so every output is a flop.
  always_comb begin
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    unique case (state_d)
      GRANT_X: begin
        sel_d        = SEL_X;
        last_owner_d = SEL_X;
      end
      GRANT_Y: begin
        sel_d        = SEL_Y;
        last_owner_d = SEL_Y;
      end
      DEAD:    sel_d = (state_q == GRANT_X) ? SEL_Y : SEL_X;
      default: sel_d = sel_q;
    endcase
    gnt_d      = gnt_of_state(state_d);
    out_en_d   = (gnt_d != GNT_NONE);
    busy_d     = (state_d != IDLE);
    cnt_clear  = (state_d != state_q);
    cnt_enable = (gnt_d != GNT_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_NONE;
      sel_q        <= SEL_X;
      out_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      last_owner_q <= SEL_Y;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      out_en_q     <= out_en_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign out_en = out_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed vector bench for mux_select_arbiter (HOLD_CYCLES = 4), covering both
// the direct-switch and MUX_SELECT_ARBITER_DEADTIME_EN builds.
module tb_mux_select_arbiter;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] req;
    logic [1:0] exp_gnt;
    logic       exp_sel;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       sel, out_en, busy;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  mux_select_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .out_en(out_en),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input string nm, input logic r, input logic [1:0] rq,
                     input logic [1:0] g, input logic s, input logic b);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.exp_gnt = g; v.exp_sel = s; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Reset held with both requesting, then continuous contention.
    add("rst_hold", 1, 2'b11, 2'b00, 0, 0);
    add("rst_hold", 1, 2'b11, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) add("alt_x1", 0, 2'b11, 2'b01, 0, 1);
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    add("alt_dead1", 0, 2'b11, 2'b00, 1, 1);
`endif
    for (int i = 0; i < 4; i++) add("alt_y", 0, 2'b11, 2'b10, 1, 1);
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    add("alt_dead2", 0, 2'b11, 2'b00, 0, 1);
`endif
    add("alt_x2", 0, 2'b11, 2'b01, 0, 1);
    add("alt_idle", 0, 2'b00, 2'b00, 0, 0);

    // Single requester x for five cycles, then drop.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) add("x_only", 0, 2'b01, 2'b01, 0, 1);
    add("x_drop", 0, 2'b00, 2'b00, 0, 0);

    // y raised while x holds: hold is honoured until tenure 4.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    add("hold_x", 0, 2'b01, 2'b01, 0, 1);
    add("hold_x", 0, 2'b01, 2'b01, 0, 1);
    add("hold_wait", 0, 2'b11, 2'b01, 0, 1);
    add("hold_wait", 0, 2'b11, 2'b01, 0, 1);
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    add("hold_dead", 0, 2'b11, 2'b00, 1, 1);
`endif
    add("hold_sw", 0, 2'b11, 2'b10, 1, 1);
    add("hold_idle", 0, 2'b00, 2'b00, 1, 0);

    // x drops at tenure 2 with y pending: early release ignores hold.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    add("early_x", 0, 2'b01, 2'b01, 0, 1);
    add("early_x", 0, 2'b11, 2'b01, 0, 1);
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    add("early_dead", 0, 2'b10, 2'b00, 1, 1);
`endif
    add("early_y", 0, 2'b10, 2'b10, 1, 1);
    add("early_idle", 0, 2'b00, 2'b00, 1, 0);

`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    // DEAD always lands in the new grant even if that requester vanished.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    add("dead_x", 0, 2'b01, 2'b01, 0, 1);
    add("dead_mid", 0, 2'b10, 2'b00, 1, 1);
    add("dead_forced", 0, 2'b00, 2'b10, 1, 1);
    add("dead_idle", 0, 2'b00, 2'b00, 1, 0);
`endif

    // Reset pulse while y owns at tenure 3, then x wins the tie.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) add("mid_y", 0, 2'b10, 2'b10, 1, 1);
    add("mid_rst", 1, 2'b11, 2'b00, 0, 0);
    add("mid_after", 0, 2'b11, 2'b01, 0, 1);

    // Long solo tenure must saturate rather than wrap.
    add("rst", 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 300; i++) add("sat_x", 0, 2'b01, 2'b01, 0, 1);
`ifdef MUX_SELECT_ARBITER_DEADTIME_EN
    add("sat_dead", 0, 2'b11, 2'b00, 1, 1);
    add("sat_sw", 0, 2'b00, 2'b10, 1, 1);
`else
    add("sat_sw", 0, 2'b11, 2'b10, 1, 1);
`endif
    add("sat_idle", 0, 2'b00, 2'b00, 1, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".gnt"},    i, gnt,           vecs[i].exp_gnt);
      chk({vecs[i].name, ".sel"},    i, {1'b0, sel},    {1'b0, vecs[i].exp_sel});
      chk({vecs[i].name, ".out_en"}, i, {1'b0, out_en}, {1'b0, |vecs[i].exp_gnt});
      chk({vecs[i].name, ".busy"},   i, {1'b0, busy},   {1'b0, vecs[i].exp_busy});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Two-requester arbiter that sequences the select line of the board's 2:1 data multiplexer (s, x, y datapath). Requester 0 owns data input x and requester 1 owns data input y. The block grants the shared mux output to one requester at a time, drives `sel` and an output-enable, and enforces a minimum tenure before the owner can be preempted. Ties are broken round-robin.

## Interface
- `HOLD_CYCLES`, default 4: minimum number of granted cycles before the owner can be preempted. Legal range 1..255.
- `CNT_W`, default 8: width of the tenure counter. Must satisfy 2^CNT_W > HOLD_CYCLES.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `req` input, 2 bits: `req[0]` is requester x, `req[1]` is requester y. Level-sensitive and held while access is wanted.
- `gnt` output, 2 bits: one-hot or zero. `gnt[i]` means requester i owns the mux output.
- `sel` output, 1 bit: mux select s. 0 selects x, 1 selects y.
- `out_en` output, 1 bit: high exactly when `gnt != 0`. Gates the mux output onto LEDR.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - GRANT_X
  - GRANT_Y
  - DEAD (exists only with DEADTIME_EN)
- Reset values:
  - state = IDLE, `gnt` = 00, `sel` = 0, `out_en` = 0, `busy` = 0, tenure count = 0.
  - last_owner = y, so x wins the first tie.
- IDLE:
  - `req` = 01 → GRANT_X.
  - `req` = 10 → GRANT_Y.
  - `req` = 11 → the requester that is not last_owner.
  - `req` = 00 → stay in IDLE.
  - `sel` holds its last value in IDLE and never toggles without a grant.
- GRANT_i:
  - `gnt[i]` = 1 and `sel` = i. The tenure count starts at 1 on the first granted cycle and saturates at HOLD_CYCLES.
- Release: the owner dropping `req[i]` releases on any cycle, regardless of tenure.
  - If the other requester is pending, go to the other grant (through DEAD if enabled).
  - If nothing is pending, go to IDLE.
- Preemption: the owner still requests, the other requests, and tenure count ≥ HOLD_CYCLES → switch to the other grant.
  - Below HOLD_CYCLES the other requester waits.
- Owner requesting alone: the grant persists indefinitely. The count saturates and does not wrap.
- last_owner is updated on every grant entry.
- Mid-operation reset: the next edge forces all reset values, with no partial-switch state retained.

## Timing
- All outputs are registered. `req` sampled at edge n affects `gnt`/`sel` at edge n+1, so latency is 1 cycle.
- Request to grant from IDLE: 1 cycle.
- Owner drops request: `gnt[i]` falls 1 cycle later.
- Direct switch (no deadtime): `gnt` goes from `01` to `10`, and `sel` goes from 0 to 1, on the same edge. There is never a cycle with both grants high.
- Both requesters held continuously: each tenure is exactly HOLD_CYCLES cycles, with strict alternation.
- `out_en` equals `|gnt` on every cycle.

## Configuration
- Macro: `MUX_SELECT_ARBITER_DEADTIME_EN`.
- Defined:
  - Every owner-to-owner switch passes through a single DEAD cycle with `gnt` = 00, `out_en` = 0, `busy` = 1, and `sel` already set to the new owner (break-before-make).
  - DEAD is followed unconditionally by the new grant, even if the new requester has dropped; that grant then releases 1 cycle later.
  - Reset during DEAD goes to IDLE.
- Undefined:
  - The DEAD state does not exist.
  - Switching is direct, as described under Timing.

## Structure
- Package `mux_arb_pkg` contains:
  - the state enum (IDLE, GRANT_X, GRANT_Y, DEAD);
  - localparams `SEL_X` = 0 and `SEL_Y` = 1;
  - the one-hot grant constants `GNT_X` = 01, `GNT_Y` = 10, `GNT_NONE` = 00.
- Sub-module `tenure_counter`:
  - A saturating CNT_W-bit counter with inputs `clear` and `enable`, and an output `expired` (count ≥ HOLD_CYCLES).
  - Synchronous active-high reset on the shared `clk`/`reset`.

## Test plan
- Reset with `req` = 11 held for 2 cycles → `gnt` = 00, `sel` = 0, `out_en` = 0, `busy` = 0 throughout. After reset releases, `gnt` = 01 on the following edge.
- `req` = 01 at cycle 0 and dropped at cycle 5 → `gnt` = 01 and `sel` = 0 in cycles 1–5. In cycle 6, `gnt` = 00 and `sel` stays 0.
- HOLD_CYCLES = 4, `req` = 11 continuously from IDLE after reset:
  - Without the macro: `gnt` = 01 in cycles 1–4, `gnt` = 10 with `sel` = 1 in cycles 5–8, then 01 again.
  - With the macro: cycle 5 has `gnt` = 00, `sel` = 1, `out_en` = 0, and cycles 6–9 have `gnt` = 10.
- x granted at cycle 1 and y raised at cycle 2 (x still requesting) → `gnt` = 01 through cycle 4 and switches at cycle 5. This checks that the hold is honoured.
- x owner with y pending drops `req[0]` at tenure cycle 2 → `gnt` = 10 on the next edge (DEAD first if enabled). This checks that early release ignores the hold.
- `reset` pulsed for 1 cycle while `gnt` = 10 at tenure 3 → `gnt` = 00 and `sel` = 0 on the next edge. With `req` = 11 afterwards, x is granted first.
